voice_mixer: RTL
================

Name: voice_mixer

Overview:
- Downstream of the per-voice dynamics stages. Combines up to three enveloped 16-bit signed voice samples into one output sample for the codec.
- On each codec request it issues a one-cycle sample request to all voices, waits a fixed pipeline latency, then sums the active voices.
- The sum is normalised or saturated, then registered with a valid pulse.
- It also flags codec requests that arrive while a mix is still in progress (overrun).

Parameters:
- VOICE_LATENCY, 3: cycles from generate_next_sample to voice samples being stable at the inputs; legal range 1-15.
- SATURATE, 1: 1 = clamp raw sum to 16-bit signed range; 0 = arithmetic-shift normalise by active-voice count.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- new_sample_ready  input  1  one-cycle pulse from codec: next output sample wanted
- voice_active  input  3  bit i = voice i currently sounding; sampled at the SUM cycle
- sample0  input  16  signed sample, voice 0
- sample1  input  16  signed sample, voice 1
- sample2  input  16  signed sample, voice 2
- generate_next_sample  output  1  one-cycle pulse to all voices
- mixed_sample  output  16  signed mixed sample; held between updates
- mixed_valid  output  1  one-cycle pulse when mixed_sample updates
- overrun  output  1  sticky; set by a request while busy
- clear_overrun  input  1  clears overrun

Behaviour:
- Clock and reset: single clock domain; all state is updated on the rising edge of clk.
- Reset values: state=IDLE, generate_next_sample=0, mixed_sample=0, mixed_valid=0, overrun=0, wait counter=0.
- Reset mid-operation aborts the mix. No mixed_valid is produced for an aborted request.
- FSM states: IDLE, REQUEST, WAIT, SUM.
  - IDLE: on new_sample_ready go to REQUEST.
  - REQUEST: generate_next_sample=1 for exactly this cycle. Load wait counter with VOICE_LATENCY-1. Go to WAIT.
  - WAIT: decrement the counter each cycle. When the counter is 0, go to SUM. Total cycles spent in WAIT = VOICE_LATENCY.
  - SUM: register the result into mixed_sample. mixed_valid=1 for this cycle. Return to IDLE.
- Latency: new_sample_ready sampled in cycle N gives generate_next_sample in N+1 and mixed_valid in N+2+VOICE_LATENCY.
- Busy and overrun:
  - The block is busy while in REQUEST, WAIT or SUM.
  - new_sample_ready while busy is dropped (not queued) and sets overrun.
  - clear_overrun clears overrun the next cycle. If clear_overrun and a dropped request occur in the same cycle, set wins.
- Arithmetic:
  - Each sample is masked by its voice_active bit (inactive contributes 0).
  - Each sample is sign-extended to 18 bits and the three are summed; the 18-bit sum cannot overflow.
- SATURATE=1: sum > 32767 gives 32767; sum < -32768 gives -32768; otherwise sum[15:0].
- SATURATE=0: arithmetic right shift by k, where k = 0 for 0 or 1 active voices, 1 for 2 active, 2 for 3 active. Result is truncated to 16 bits. Negative values round toward minus infinity.
- No active voices: mixed_sample=0, and mixed_valid still pulses.
- Inputs sample0-2 and voice_active are only looked at in SUM. Changes during WAIT are ignored.

Test Plan:
1. Reset, then new_sample_ready pulse at cycle 10 with VOICE_LATENCY=3 -> generate_next_sample high in cycle 11 only; mixed_valid high in cycle 15 only; mixed_sample=0 before and at reset.
2. SATURATE=1, voice_active=3'b111, samples 20000/20000/-5000 -> mixed_sample=32767. Samples -20000/-20000/0 -> -32768. Samples 100/-300/50 -> -150.
3. SATURATE=0, voice_active=3'b011, samples 1000/-3001, voice 2 = 7777 (ignored) -> sum -2001, mixed_sample=-1001. voice_active=3'b111 with 4000/4000/4000 -> 3000.
4. new_sample_ready repeated on every cycle during WAIT -> exactly one generate_next_sample and one mixed_valid; overrun=1 and stays 1 afterwards; clear_overrun pulse -> overrun=0 next cycle.
5. Reset asserted in the middle of WAIT -> no mixed_valid; state IDLE; mixed_sample=0. A new request after reset completes normally with full latency.
6. voice_active=3'b000 with nonzero samples -> mixed_sample=0 and mixed_valid pulses. Back-to-back requests spaced exactly 3+VOICE_LATENCY cycles apart -> every request is served and overrun stays 0.

Source files
------------

// File: rtl/voice_mixer.sv
// Three-voice sample mixer: on each codec request it pulses the voices,
// waits VOICE_LATENCY cycles, then outputs the saturated or normalised sum.
module voice_mixer #(
    parameter int VOICE_LATENCY = 3,
    parameter bit SATURATE      = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               new_sample_ready,
    input  logic [2:0]         voice_active,
    input  logic signed [15:0] sample0,
    input  logic signed [15:0] sample1,
    input  logic signed [15:0] sample2,
    input  logic               clear_overrun,
    output logic               generate_next_sample,
    output logic signed [15:0] mixed_sample,
    output logic               mixed_valid,
    output logic               overrun
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_REQUEST = 2'd1;
    localparam logic [1:0] S_WAIT    = 2'd2;
    localparam logic [1:0] S_SUM     = 2'd3;

    localparam logic [3:0] WAIT_LOAD = 4'(VOICE_LATENCY - 1);

    logic [1:0]         state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic signed [15:0] mixed_q, mixed_d;
    logic               overrun_q, overrun_d;

    logic signed [17:0] ext0, ext1, ext2, sum18, shifted;
    logic signed [15:0] result;
    logic               busy;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE:    if (new_sample_ready) state_d = S_REQUEST;
            S_REQUEST: begin
                cnt_d   = WAIT_LOAD;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) state_d = S_SUM;
                else               cnt_d   = cnt_q - 4'd1;
            end
            default:   state_d = S_IDLE;
        endcase
    end

    // Masked, sign-extended operands; three 16-bit values cannot overflow 18 bits.
    always_comb begin
        ext0  = voice_active[0] ? {{2{sample0[15]}}, sample0} : 18'sd0;
        ext1  = voice_active[1] ? {{2{sample1[15]}}, sample1} : 18'sd0;
        ext2  = voice_active[2] ? {{2{sample2[15]}}, sample2} : 18'sd0;
        sum18 = ext0 + ext1 + ext2;
    end

    always_comb begin
        shifted = sum18;
        result  = sum18[15:0];
        if (SATURATE) begin
            if (sum18 > 18'sd32767)       result = 16'sh7fff;
            else if (sum18 < -18'sd32768) result = -16'sh8000;
        end else begin
            case (voice_active)
                3'b011, 3'b101, 3'b110: shifted = sum18 >>> 1;
                3'b111:                 shifted = sum18 >>> 2;
                default:                shifted = sum18;
            endcase
            result = shifted[15:0];
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign mixed_d   = (state_q == S_SUM) ? result : mixed_q;
    // A dropped request in the same cycle as a clear keeps the flag set.
    assign overrun_d = (new_sample_ready && busy) ? 1'b1 :
                       clear_overrun              ? 1'b0 : overrun_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            mixed_q   <= 16'sd0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mixed_q   <= mixed_d;
            overrun_q <= overrun_d;
        end
    end

    // The SUM-cycle result is forwarded so data and valid appear together.
    assign generate_next_sample = (state_q == S_REQUEST);
    assign mixed_valid          = (state_q == S_SUM);
    assign mixed_sample         = mixed_d;
    assign overrun              = overrun_q;

endmodule
